// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter (configurable data/parity/stop bits) fed by a synchronous TX FIFO.
// Optional hardware flow control: define UART_TX_CTS_EN to add the ctsInN input.
module uart_tx_fifo #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clkIn,
  input  logic                          nTxResetIn,
  input  logic [DATA_BITS-1:0]          txDataIn,
  input  logic                          txLoadIn,
  output logic                          txReadyOut,
  output logic                          txIdleOut,
  output logic [$clog2(FIFO_DEPTH):0]   txLevelOut,
  output logic                          txOverflowOut,
`ifdef UART_TX_CTS_EN
  input  logic                          ctsInN,
`endif
  output logic                          txOut
);

  localparam int BAUD_DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP   = 1'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(FIFO_DEPTH);

  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } txStateT;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr;
  logic [PTR_W-1:0]     rdPtr;
  logic [LVL_W-1:0]     level;
  logic [DATA_BITS-1:0] fifoHead;
  logic                 push;
  logic                 pop;
  logic                 fifoEmpty;

  assign txReadyOut = (level != FULL_LEVEL);
  assign txLevelOut = level;
  assign fifoEmpty  = (level == '0);
  assign push       = txLoadIn && txReadyOut;
  assign fifoHead   = fifoMem[rdPtr];

  // NOTE: the storage array has no reset; an entry is only read after it has been
  // written, and the pointers and level carry the reset state.
  always_ff @(posedge clkIn) begin
    if (push) fifoMem[wrPtr] <= txDataIn;
  end

  always_ff @(posedge clkIn or negedge nTxResetIn) begin
    if (!nTxResetIn) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      level         <= '0;
      txOverflowOut <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (txLoadIn && !txReadyOut) txOverflowOut <= 1'b1;
    end
  end

  // ------------------------------------------------------------ flow control
  logic ctsOk;

`ifdef UART_TX_CTS_EN
  logic [1:0] ctsSync;

  always_ff @(posedge clkIn or negedge nTxResetIn) begin
    if (!nTxResetIn) ctsSync <= 2'b11;
    else             ctsSync <= {ctsSync[0], ctsInN};
  end

  assign ctsOk = ~ctsSync[1];
`else
  assign ctsOk = 1'b1;
`endif

  // ------------------------------------------------------------ transmitter
  txStateT              state;
  txStateT              stateNext;
  logic [CNT_W-1:0]     baudCnt;
  logic [CNT_W-1:0]     baudCntNext;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DATA_BITS-1:0] shiftNext;
  logic [IDX_W-1:0]     bitIdx;
  logic [IDX_W-1:0]     bitIdxNext;
  logic                 stopIdx;
  logic                 stopIdxNext;
  logic                 parityReg;
  logic                 parityNext;
  logic                 txNext;
  logic                 bitTick;
  logic                 canStart;
  logic                 startFrame;

  assign bitTick   = (state != ST_IDLE) && (baudCnt == '0);
  assign canStart  = !fifoEmpty && ctsOk;
  assign txIdleOut = fifoEmpty && (state == ST_IDLE) && txOut;

  function automatic logic frameParity(input logic [DATA_BITS-1:0] word);
    return (PARITY == 1) ? ~(^word) : ^word;
  endfunction

  always_ff @(posedge clkIn or negedge nTxResetIn) begin
    if (!nTxResetIn) state <= ST_IDLE;
    else             state <= stateNext;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    stateNext   = state;
    baudCntNext = baudCnt;
    shiftNext   = shiftReg;
    bitIdxNext  = bitIdx;
    stopIdxNext = stopIdx;
    parityNext  = parityReg;
    txNext      = txOut;
    startFrame  = 1'b0;
    pop         = 1'b0;

    if (state != ST_IDLE) baudCntNext = bitTick ? BAUD_RELOAD : baudCnt - CNT_W'(1);

    unique case (state)
      ST_IDLE: begin
        baudCntNext = '0;
        startFrame  = canStart;
      end
      ST_START: begin
        if (bitTick) begin
          txNext     = shiftReg[0];
          shiftNext  = shiftReg >> 1;
          bitIdxNext = '0;
          stateNext  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bitTick) begin
          if (bitIdx == LAST_IDX) begin
            stopIdxNext = 1'b0;
            if (PARITY != 0) begin
              txNext    = parityReg;
              stateNext = ST_PARITY;
            end else begin
              txNext    = 1'b1;
              stateNext = ST_STOP;
            end
          end else begin
            txNext     = shiftReg[0];
            shiftNext  = shiftReg >> 1;
            bitIdxNext = bitIdx + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bitTick) begin
          txNext      = 1'b1;
          stopIdxNext = 1'b0;
          stateNext   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bitTick) begin
          if (stopIdx == LAST_STOP) begin
            if (canStart) begin
              startFrame = 1'b1;
            end else begin
              baudCntNext = '0;
              stateNext   = ST_IDLE;
            end
          end else begin
            stopIdxNext = 1'b1;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    // Back-to-back frames reuse the same load path as a start from idle.
    if (startFrame) begin
      pop         = 1'b1;
      shiftNext   = fifoHead;
      parityNext  = frameParity(fifoHead);
      txNext      = 1'b0;
      baudCntNext = BAUD_RELOAD;
      stateNext   = ST_START;
    end
  end

  always_ff @(posedge clkIn or negedge nTxResetIn) begin
    if (!nTxResetIn) begin
      txOut     <= 1'b1;
      baudCnt   <= '0;
      shiftReg  <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      parityReg <= 1'b0;
    end else begin
      txOut     <= txNext;
      baudCnt   <= baudCntNext;
      shiftReg  <= shiftNext;
      bitIdx    <= bitIdxNext;
      stopIdx   <= stopIdxNext;
      parityReg <= parityNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four frame formats at BAUD_DIV=10, FIFO fill/overflow,
// asynchronous reset mid-frame, and CTS gating when UART_TX_CTS_EN is defined.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;

  logic clkIn;
  logic nTxResetIn;

  logic [7:0] aData;
  logic       aLoad, aReady, aIdle, aOvf, aTx;
  logic [4:0] aLevel;
  logic [7:0] bData;
  logic       bLoad, bReady, bIdle, bOvf, bTx;
  logic [4:0] bLevel;
  logic [7:0] cData;
  logic       cLoad, cReady, cIdle, cOvf, cTx;
  logic [4:0] cLevel;
  logic [6:0] dData;
  logic       dLoad, dReady, dIdle, dOvf, dTx;
  logic [4:0] dLevel;
`ifdef UART_TX_CTS_EN
  logic ctsInN;
`endif

  logic [3:0] txLine;
  assign txLine = {dTx, cTx, bTx, aTx};

  int nCompared   = 0;
  int nMismatched = 0;

  uart_tx_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dutA (
    .clkIn(clkIn), .nTxResetIn(nTxResetIn), .txDataIn(aData), .txLoadIn(aLoad),
    .txReadyOut(aReady), .txIdleOut(aIdle), .txLevelOut(aLevel), .txOverflowOut(aOvf),
`ifdef UART_TX_CTS_EN
    .ctsInN(ctsInN),
`endif
    .txOut(aTx));

  uart_tx_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dutB (
    .clkIn(clkIn), .nTxResetIn(nTxResetIn), .txDataIn(bData), .txLoadIn(bLoad),
    .txReadyOut(bReady), .txIdleOut(bIdle), .txLevelOut(bLevel), .txOverflowOut(bOvf),
`ifdef UART_TX_CTS_EN
    .ctsInN(ctsInN),
`endif
    .txOut(bTx));

  uart_tx_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dutC (
    .clkIn(clkIn), .nTxResetIn(nTxResetIn), .txDataIn(cData), .txLoadIn(cLoad),
    .txReadyOut(cReady), .txIdleOut(cIdle), .txLevelOut(cLevel), .txOverflowOut(cOvf),
`ifdef UART_TX_CTS_EN
    .ctsInN(ctsInN),
`endif
    .txOut(cTx));

  uart_tx_fifo #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) dutD (
    .clkIn(clkIn), .nTxResetIn(nTxResetIn), .txDataIn(dData), .txLoadIn(dLoad),
    .txReadyOut(dReady), .txIdleOut(dIdle), .txLevelOut(dLevel), .txOverflowOut(dOvf),
`ifdef UART_TX_CTS_EN
    .ctsInN(ctsInN),
`endif
    .txOut(dTx));

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line level k cycles after the edge that starts the frame (k=1 is the first start-bit cycle).
  function automatic logic expBit(input logic [8:0] word, input int nBits, input int hasPar,
                                  input logic parBit, input int k);
    int slot;
    slot = (k - 1) / 10;
    if (slot == 0)                          return 1'b0;
    if (slot <= nBits)                      return word[slot-1];
    if (hasPar != 0 && slot == nBits + 1)   return parBit;
    return 1'b1;
  endfunction

  task automatic checkFrame(input int u, input logic [8:0] word, input int nBits,
                            input int hasPar, input logic parBit, input int kFirst,
                            input int kLast, input string tag);
    for (int k = kFirst; k <= kLast; k++) begin
      @(negedge clkIn);
      check($sformatf("%s_k%0d", tag, k), 32'(txLine[u]), 32'(expBit(word, nBits, hasPar, parBit, k)));
    end
  endtask

  initial begin
    int highCnt;
    aData = '0; aLoad = 1'b0;
    bData = '0; bLoad = 1'b0;
    cData = '0; cLoad = 1'b0;
    dData = '0; dLoad = 1'b0;
`ifdef UART_TX_CTS_EN
    ctsInN = 1'b0;
`endif
    nTxResetIn = 1'b0;
    repeat (3) @(negedge clkIn);

    check("rst_tx",    32'(aTx),    32'd1);
    check("rst_ready", 32'(aReady), 32'd1);
    check("rst_idle",  32'(aIdle),  32'd1);
    check("rst_level", 32'(aLevel), 32'd0);
    check("rst_ovf",   32'(aOvf),   32'd0);
    check("rst_tx_d",  32'(dTx),    32'd1);
    nTxResetIn = 1'b1;
    repeat (2) @(negedge clkIn);

    // 8N1, 0xA5: start at E+1, LSB first, stop, idle at E+101.
    aData = 8'hA5; aLoad = 1'b1;
    @(negedge clkIn);
    aLoad = 1'b0;
    check("t1_tx_at_E",    32'(aTx),    32'd1);
    check("t1_level_at_E", 32'(aLevel), 32'd1);
    check("t1_idle_at_E",  32'(aIdle),  32'd0);
    checkFrame(0, 9'h0A5, 8, 0, 1'b0, 1, 100, "t1");
    check("t1_idle_E100", 32'(aIdle), 32'd0);
    @(negedge clkIn);
    check("t1_idle_E101",  32'(aIdle),  32'd1);
    check("t1_level_E101", 32'(aLevel), 32'd0);

    // Even parity of 0x07 (three ones) is 1; odd parity is 0. 110-cycle frames.
    bData = 8'h07; bLoad = 1'b1;
    @(negedge clkIn);
    bLoad = 1'b0;
    checkFrame(1, 9'h007, 8, 1, 1'b1, 1, 110, "t2even");
    @(negedge clkIn);
    check("t2even_idle", 32'(bIdle), 32'd1);

    cData = 8'h07; cLoad = 1'b1;
    @(negedge clkIn);
    cLoad = 1'b0;
    checkFrame(2, 9'h007, 8, 1, 1'b0, 1, 110, "t2odd");
    @(negedge clkIn);
    check("t2odd_idle", 32'(cIdle), 32'd1);

    // 18 consecutive writes: the first is popped at the second edge, so 17 fit.
    for (int i = 0; i < 18; i++) begin
      aData = 8'(i); aLoad = 1'b1;
      if (i == 16) check("t3_ready_16", 32'(aReady), 32'd1);
      if (i == 17) begin
        check("t3_ready_17", 32'(aReady), 32'd0);
        check("t3_level_17", 32'(aLevel), 32'd16);
        check("t3_ovf_17",   32'(aOvf),   32'd0);
      end
      @(negedge clkIn);
    end
    aLoad = 1'b0;
    check("t3_ovf",   32'(aOvf),   32'd1);
    check("t3_level", 32'(aLevel), 32'd16);

    // Word 0x00 is now mid-DATA; an asynchronous reset aborts it and flushes the queue.
    repeat (12) @(negedge clkIn);
    check("t5_mid_tx",    32'(aTx),    32'd0);
    check("t5_mid_level", 32'(aLevel), 32'd16);
    nTxResetIn = 1'b0;
    #1;
    check("t5_tx",    32'(aTx),    32'd1);
    check("t5_level", 32'(aLevel), 32'd0);
    check("t5_idle",  32'(aIdle),  32'd1);
    check("t5_ovf",   32'(aOvf),   32'd0);
    check("t5_ready", 32'(aReady), 32'd1);
    @(negedge clkIn);
    nTxResetIn = 1'b1;
    highCnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clkIn);
      if (aTx === 1'b1) highCnt++;
    end
    check("t5_quiet_cycles", 32'(highCnt), 32'd150);
    check("t5_quiet_level",  32'(aLevel),  32'd0);

    // 7N2, 0x55 then 0x2A: two 100-cycle frames with no gap.
    dData = 7'h55; dLoad = 1'b1;
    @(negedge clkIn);
    dData = 7'h2A;
    @(negedge clkIn);
    dLoad = 1'b0;
    check("t4a_k1",    32'(dTx),    32'd0);
    check("t4_level1", 32'(dLevel), 32'd1);
    checkFrame(3, 9'h055, 7, 0, 1'b0, 2, 100, "t4a");
    checkFrame(3, 9'h02A, 7, 0, 1'b0, 1, 100, "t4b");
    check("t4_level_end", 32'(dLevel), 32'd0);
    @(negedge clkIn);
    check("t4_idle_end", 32'(dIdle), 32'd1);

`ifdef UART_TX_CTS_EN
    // CTS deasserted holds the frame; once asserted the frame starts and always completes.
    begin
      bit started;
      ctsInN = 1'b1;
      repeat (5) @(negedge clkIn);
      aData = 8'h3C; aLoad = 1'b1;
      @(negedge clkIn);
      aLoad = 1'b0;
      highCnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clkIn);
        if (aTx === 1'b1) highCnt++;
      end
      check("t6_held_cycles", 32'(highCnt), 32'd20);
      check("t6_held_level",  32'(aLevel),  32'd1);
      ctsInN  = 1'b0;
      started = 1'b0;
      for (int i = 0; i < 3 && !started; i++) begin
        @(negedge clkIn);
        if (aTx === 1'b0) started = 1'b1;
      end
      check("t6_start_within_3", 32'(started), 32'd1);
      checkFrame(0, 9'h03C, 8, 0, 1'b0, 2, 40, "t6");
      ctsInN = 1'b1;
      checkFrame(0, 9'h03C, 8, 0, 1'b0, 41, 100, "t6");
      @(negedge clkIn);
      check("t6_idle", 32'(aIdle), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
